// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment scan controller.
// Segment patterns are gfedcba, active-high.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;

    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111101;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1101111;

    typedef enum logic {
        PH_BLANK,
        PH_SHOW
    } phase_e;

    // Counter width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD to 7-segment decoder, gfedcba active-high.
// Codes above 9 show a dash.
import seg7_pkg::*;

module bcd_to_7seg (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// One shared decoder, per-slot blanking gap, frame snapshot, leading-zero blanking.
import seg7_pkg::*;

module seg7_scan_ctrl #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lzb,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int CW = idx_w(REFRESH_DIV);
    localparam int IW = idx_w(DIGITS);

    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] sh_val;
    logic [DIGITS-1:0]   sh_dp;

    logic [3:0] cur_bcd;
    logic       cur_dp;
    logic [6:0] dec_seg;
    logic       lz_hit;
    logic       slot_end;
    phase_e     phase;

    always_comb begin
        cur_bcd = 4'd0;
        cur_dp  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_bcd = sh_val[4*i +: 4];
                cur_dp  = sh_dp[i];
            end
        end
    end

    // A digit is a leading zero when it and everything left of it is 0 with no DP.
    always_comb begin
        lz_hit = lzb && (idx != '0);
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) >= idx && (sh_val[4*i +: 4] != 4'd0 || sh_dp[i]))
                lz_hit = 1'b0;
        end
    end

    always_comb begin
        slot_end = (cnt == CNT_LAST);
        phase    = (cnt < CNT_BLANK || lz_hit) ? PH_BLANK : PH_SHOW;
    end

    bcd_to_7seg u_dec (
        .bcd (cur_bcd),
        .seg (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            idx    <= '0;
            sh_val <= '0;
            sh_dp  <= '0;
            seg    <= SEG_BLANK;
            dp     <= 1'b0;
            an     <= '0;
            frame  <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            idx   <= '0;
            seg   <= SEG_BLANK;
            dp    <= 1'b0;
            an    <= '0;
            frame <= 1'b0;
        end else begin
            if (cnt == '0 && idx == '0) begin
                sh_val <= value;
                sh_dp  <= dp_in;
            end
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            frame <= slot_end && (idx == IDX_LAST);
            if (phase == PH_SHOW) begin
                an  <= DIGITS'(1) << idx;
                seg <= dec_seg;
                dp  <= cur_dp;
            end else begin
                an  <= '0;
                seg <= SEG_BLANK;
                dp  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-segment multi-digit 7-segment display. It shares one bcd_to_7seg decoder between DIGITS BCD digits. Each digit gets a fixed slot, with a blanking gap at the start of the slot to prevent ghosting. It sits between the counter/timer logic that produces packed BCD values and the display pins.

Parameters:
DIGITS, 4, number of digits scanned (1..8)
REFRESH_DIV, 50000, clock cycles per digit slot (must be > BLANK_CYCLES)
BLANK_CYCLES, 500, cycles at start of each slot with all anodes off (0 allowed)

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  synchronous reset, active-low
EN  input  1  scan enable; low = display dark, scan held at start
VALUE  input  4*DIGITS  packed BCD digits, digit i = VALUE[4i+3:4i], digit 0 = rightmost
DP_IN  input  DIGITS  decimal point request per digit
LZB  input  1  leading-zero blanking enable
SEG  output  7  segment drive, gfedcba, active-high
DP  output  1  decimal point drive, active-high
AN  output  DIGITS  one-hot digit enable, active-high
FRAME  output  1  one-cycle pulse at end of each full scan

Behaviour:
- Reset: synchronous, active-low, sampled on rising CLK. While RST_N=0, the next edge sets cnt=0, idx=0, shadow VALUE/DP=0, SEG=0, DP=0, AN=0, FRAME=0.
- All outputs are registered: the output in cycle t+1 is a function of cnt, idx and shadow in cycle t.
- cnt counts 0..REFRESH_DIV-1 while EN=1. On wrap, idx advances 0..DIGITS-1 and then wraps to 0.
- Snapshot: on a cycle with EN=1, cnt=0 and idx=0, VALUE and DP_IN are latched into the shadow registers. The display uses only the shadow, so there is no mid-frame tearing.
- Slot phase BLANK (cnt < BLANK_CYCLES): AN=0, SEG=0, DP=0.
- Slot phase SHOW (cnt >= BLANK_CYCLES):
  - AN = 1<<idx.
  - SEG = decode(shadow digit idx), using gfedcba encoding.
  - DP = shadow DP bit idx.
- Decode: 0-9 use standard patterns; codes 10-15 give 7'b1000000 ("-").
- Leading-zero blanking applies when LZB=1 and digit idx>0. A digit is blanked if every shadow digit from idx up to DIGITS-1 is 0 and the shadow DP bits for those same digits are all 0.
  - A blanked digit behaves as BLANK phase for the whole slot.
  - Digit 0 is never blanked.
- FRAME=1 for exactly one cycle, after a cycle with EN=1, idx=DIGITS-1 and cnt=REFRESH_DIV-1.
- EN=0: the next edge sets cnt=0, idx=0, AN=0, SEG=0, DP=0, FRAME=0; the shadow is held.
  - When EN returns to 1, the scan restarts at digit 0 with a fresh snapshot and a full blank gap.
- RST_N low mid-slot: all outputs are 0 on the next edge; the scan restarts as above.
- BLANK_CYCLES=0: no gap. AN moves directly from one digit to the next, and SEG changes on the same edge.
- DIGITS=1: idx is constant 0, and FRAME pulses once per slot.
- Width: cnt is $clog2(REFRESH_DIV) bits; idx is max(1,$clog2(DIGITS)) bits. No overflow is possible because both counters wrap explicitly.

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK = 7'b0000000 and SEG_DASH = 7'b1000000.
  - Digit-pattern constants for 0-9 (gfedcba).
  - Helper function for the index width.
- Sub-module: one instance of bcd_to_7seg (4-bit BCD in, 7-bit gfedcba out, "-" for codes >9).
  - It is fed by a 4:1..8:1 mux of the shadow digits indexed by idx.
  - Its output is registered into SEG.
- The scan FSM (BLANK/SHOW derived from cnt), counters, snapshot and LZB logic stay in this module.

Test Plan (DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2):
1. Reset: hold RST_N=0 for 3 cycles with EN=1, VALUE=16'h1234 -> AN=0000, SEG=0, DP=0, FRAME=0 throughout; after release, the first 2 cycles have AN=0000.
2. Basic scan: VALUE=16'h1234, LZB=0, DP_IN=0100. Each slot is 2 cycles of AN=0000 followed by 6 cycles of the digit:
   - digit 0: AN=0001, SEG=1100110 ("4")
   - digit 1: AN=0010, SEG=1001111 ("3")
   - digit 2: AN=0100, SEG=1011011 ("2"), DP=1
   - digit 3: AN=1000, SEG=0000110 ("1")
   - FRAME pulses every 32 cycles.
3. Leading-zero blanking: LZB=1.
   - VALUE=16'h0070 -> AN bits 3 and 2 are never set; digit 1 shows SEG=0000111; digit 0 shows SEG=0111111.
   - VALUE=16'h0000 -> only digit 0 lights, showing "0".
   - VALUE=16'h0000 with DP_IN=0100 -> digits 2, 1 and 0 light.
4. Snapshot: change VALUE from 16'h1234 to 16'h5678 during the digit 2 slot -> digits 2 and 3 still show "2" and "1"; the next frame shows 8, 7, 6, 5.
5. Invalid code: VALUE=16'h00A0 -> digit 1 shows SEG=1000000.
6. EN/reset mid-frame: drop EN for 1 cycle during the digit 2 SHOW phase -> AN=0000 on the next edge. After EN returns: 2 blank cycles, then AN=0001. Repeat the same sequence with RST_N instead of EN.
